if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage feeding the instruction memory (im). Holds the PC, drives
//   the word-aligned fetch address, captures the returned word into the IF/ID register,
//   and supplies the PC, PC+4 (jal link value) and a valid flag to decode.
//   Supports decode back-pressure (stall) and redirect from branch/jump/jr resolution.
// PARAMETERS
//   RESET_VECTOR  32'h0000_00A0  PC loaded on reset (word 40 of im)
//   IMEM_WORDS    256            im depth in 32-bit words; fetch with PC>>2 >= this errors
// PORTS
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   run_en         in   1   1 = fetch enabled; 0 = park in IDLE
//   stall          in   1   decode cannot accept; hold PC and IF/ID register
//   redirect       in   1   replace PC with redirect_pc at next edge; flush IF/ID
//   redirect_pc    in   32  redirect target byte address
//   imem_addr      out  32  fetch byte address to im (combinational = PC)
//   imem_data      in   32  im read word (combinational from imem_addr)
//   if_instr       out  32  captured instruction
//   if_pc          out  32  address of if_instr
//   if_pc_plus4    out  32  if_pc + 4 (link value for jal)
//   if_valid       out  1   if_instr/if_pc/if_pc_plus4 valid
//   fetch_err      out  1   sticky: misaligned redirect or out-of-range fetch
// BEHAVIOUR
//   Reset (async, rst_n=0): PC=RESET_VECTOR, state=IDLE, if_instr=0, if_pc=0,
//     if_pc_plus4=0, if_valid=0, fetch_err=0. imem_addr=PC at all times (also in reset).
//   States: IDLE, RUN, ERR.
//   IDLE: no capture, if_valid<=0, PC held. run_en=1 -> RUN at next edge.
//     redirect in IDLE: PC<=redirect_pc (alignment checked, error -> ERR).
//   RUN, per edge, priority order:
//     1 redirect=1: redirect_pc[1:0]!=0 -> ERR, fetch_err<=1, if_valid<=0, PC unchanged;
//       else PC<=redirect_pc, if_valid<=0 (flush). Redirect overrides stall.
//     2 stall=1: PC, if_instr, if_pc, if_pc_plus4, if_valid all held.
//     3 run_en=0: if_valid<=0, PC held, -> IDLE.
//     4 (PC>>2)>=IMEM_WORDS: -> ERR, fetch_err<=1, if_valid<=0, PC held.
//     5 else: if_instr<=imem_data, if_pc<=PC, if_pc_plus4<=PC+4, if_valid<=1, PC<=PC+4.
//   Latency: PC presented in cycle N -> if_valid with that instruction after edge N+1.
//   Throughput: one instruction per cycle when stall=0 and no redirect.
//   Handshake: item consumed on any edge with if_valid=1 and stall=0; a stalled item
//     stays stable until consumed or flushed by redirect.
//   Arithmetic: PC+4 modulo 2^32 (0xFFFF_FFFC wraps to 0); range check triggers first.
//   ERR: terminal; outputs frozen except if_valid=0, fetch_err=1; exit only via rst_n.
//   Reset asserted mid-operation: all state returns to reset values immediately,
//     without waiting for clk; in-flight instruction dropped.
// TESTING
//   1 Reset, run_en=0 -> imem_addr=0xA0, if_valid=0, fetch_err=0 for 5 cycles.
//   2 run_en=1, stall=0 -> successive if_pc 0xA0,0xA4,0xA8 with if_instr 0x20080007,
//     0x20090008, 0x0C00000B; if_pc_plus4 = 0xA4,0xA8,0xAC; if_valid=1 from 2nd edge.
//   3 stall=1 for 3 cycles while if_pc=0xA4 -> if_instr=0x20090008 held, imem_addr
//     stays 0xA8; release -> if_pc 0xA8 next edge, no skip or duplicate.
//   4 redirect=1, redirect_pc=0x30 with stall=1 -> next edge if_valid=0, imem_addr=0x30;
//     following edge if_instr=0x03E00008, if_pc=0x30.
//   5 redirect_pc=0x32 -> fetch_err=1, if_valid=0, stays so until rst_n; redirect to
//     0x3FC then run -> 0x3FC fetched, next fetch at 0x400 sets fetch_err.
//   6 rst_n pulsed low mid-cycle during RUN at PC=0xB0 -> outputs reset without clk
//     edge; after release + run_en, fetch restarts at 0xA0.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - fetch-stage bundle: control inputs, instruction memory port, IF/ID outputs
interface if_fetch_unit_if;
   logic        run_en;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_valid;
   logic        fetch_err;

   modport master (
      input  run_en, stall, redirect, redirect_pc, imem_data,
      output imem_addr, if_instr, if_pc, if_pc_plus4, if_valid, fetch_err
   );

   modport slave (
      output run_en, stall, redirect, redirect_pc, imem_data,
      input  imem_addr, if_instr, if_pc, if_pc_plus4, if_valid, fetch_err
   );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem address, IF/ID register, stall and redirect
module if_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_00A0,
   parameter int unsigned IMEM_WORDS   = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   if_fetch_unit_if.master bus
);
   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [31:0] instr_q, instr_nx;
   logic [31:0] ipc_q, ipc_nx;
   logic [31:0] ip4_q, ip4_nx;
   logic        valid_q, valid_nx;
   logic        err_q, err_nx;
   logic        redirect_bad;
   logic        out_of_range;

   assign redirect_bad = bus.redirect_pc[1:0] != 2'b00;
   // Range check runs before the PC+4 wrap can ever be observed.
   assign out_of_range = {2'b00, pc[31:2]} >= IMEM_LIMIT;

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      instr_nx = instr_q;
      ipc_nx   = ipc_q;
      ip4_nx   = ip4_q;
      valid_nx = valid_q;
      err_nx   = err_q;
      case (state)
         IDLE: begin
            valid_nx = 1'b0;
            if (bus.redirect && redirect_bad) begin
               state_nx = ERR;
               err_nx   = 1'b1;
            end else begin
               if (bus.redirect) pc_nx = bus.redirect_pc;
               if (bus.run_en) state_nx = RUN;
            end
         end
         RUN: begin
            if (bus.redirect) begin
               valid_nx = 1'b0;
               if (redirect_bad) begin
                  state_nx = ERR;
                  err_nx   = 1'b1;
               end else begin
                  pc_nx = bus.redirect_pc;
               end
            end else if (bus.stall) begin
               valid_nx = valid_q;
            end else if (!bus.run_en) begin
               valid_nx = 1'b0;
               state_nx = IDLE;
            end else if (out_of_range) begin
               valid_nx = 1'b0;
               err_nx   = 1'b1;
               state_nx = ERR;
            end else begin
               instr_nx = bus.imem_data;
               ipc_nx   = pc;
               ip4_nx   = pc + 32'd4;
               valid_nx = 1'b1;
               pc_nx    = pc + 32'd4;
            end
         end
         ERR: begin
            valid_nx = 1'b0;
            err_nx   = 1'b1;
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= RESET_VECTOR;
         instr_q <= 32'd0;
         ipc_q   <= 32'd0;
         ip4_q   <= 32'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         pc      <= pc_nx;
         instr_q <= instr_nx;
         ipc_q   <= ipc_nx;
         ip4_q   <= ip4_nx;
         valid_q <= valid_nx;
         err_q   <= err_nx;
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.if_instr    = instr_q;
   assign bus.if_pc       = ipc_q;
   assign bus.if_pc_plus4 = ip4_q;
   assign bus.if_valid    = valid_q;
   assign bus.fetch_err   = err_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and randomized bench for if_fetch_unit with a spec-level model
module tb_if_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] mem [256];

   if_fetch_unit_if bus();

   if_fetch_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus.imem_data = 32'hBAD0_BAD0;
      if (bus.imem_addr < 32'h400) bus.imem_data = mem[bus.imem_addr[9:2]];
   end

   // Reference model: spec rules over plain variables
   bit          m_running, m_dead, m_valid;
   logic [31:0] m_pc, m_instr, m_ipc, m_ip4;

   function automatic void model_reset();
      m_running = 0; m_dead = 0; m_valid = 0;
      m_pc = 32'hA0; m_instr = 0; m_ipc = 0; m_ip4 = 0;
   endfunction

   function automatic void model_edge(bit run_en, bit stall, bit redirect, logic [31:0] rpc);
      if (m_dead) begin
         m_valid = 0;
      end else if (!m_running) begin
         m_valid = 0;
         if (redirect && (rpc % 4 != 0)) m_dead = 1;
         else begin
            if (redirect) m_pc = rpc;
            m_running = run_en;
         end
      end else if (redirect) begin
         m_valid = 0;
         if (rpc % 4 != 0) m_dead = 1;
         else m_pc = rpc;
      end else if (stall) begin
         m_valid = m_valid;
      end else if (!run_en) begin
         m_valid = 0;
         m_running = 0;
      end else if (m_pc / 4 >= 256) begin
         m_dead = 1;
         m_valid = 0;
      end else begin
         m_instr = mem[m_pc / 4];
         m_ipc = m_pc;
         m_ip4 = m_pc + 4;
         m_valid = 1;
         m_pc = m_pc + 4;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string where);
      check({where, ".imem_addr"}, bus.imem_addr, m_pc);
      check({where, ".if_valid"}, {31'd0, bus.if_valid}, {31'd0, m_valid});
      check({where, ".fetch_err"}, {31'd0, bus.fetch_err}, {31'd0, m_dead});
      check({where, ".if_instr"}, bus.if_instr, m_instr);
      check({where, ".if_pc"}, bus.if_pc, m_ipc);
      check({where, ".if_pc_plus4"}, bus.if_pc_plus4, m_ip4);
   endtask

   task automatic drive(input bit run_en, input bit stall, input bit redirect, input logic [31:0] rpc);
      bus.run_en = run_en;
      bus.stall = stall;
      bus.redirect = redirect;
      bus.redirect_pc = rpc;
   endtask

   task automatic step(input string where);
      @(posedge clk);
      model_edge(bus.run_en, bus.stall, bus.redirect, bus.redirect_pc);
      #1;
      compare_all(where);
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("async_rst");
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[40] = 32'h2008_0007;
      mem[41] = 32'h2009_0008;
      mem[42] = 32'h0C00_000B;
      mem[12] = 32'h03E0_0008;
      drive(0, 0, 0, 32'h0);
      model_reset();

      // Reset state, including while rst_n is still low
      #12;
      compare_all("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step("idle");
      check("idle_addr", bus.imem_addr, 32'hA0);

      // Straight-line fetch
      drive(1, 0, 0, 32'h0);
      step("enter_run");
      check("first_valid", {31'd0, bus.if_valid}, 32'd0);
      step("fetch0");
      check("f0_pc", bus.if_pc, 32'hA0);
      check("f0_instr", bus.if_instr, 32'h2008_0007);
      check("f0_pc4", bus.if_pc_plus4, 32'hA4);
      check("f0_valid", {31'd0, bus.if_valid}, 32'd1);
      step("fetch1");
      check("f1_pc", bus.if_pc, 32'hA4);

      // Stall holds IF/ID and PC
      drive(1, 1, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step("stall");
         check("stall_instr", bus.if_instr, 32'h2009_0008);
         check("stall_addr", bus.imem_addr, 32'hA8);
      end
      drive(1, 0, 0, 32'h0);
      step("release");
      check("rel_pc", bus.if_pc, 32'hA8);
      check("rel_instr", bus.if_instr, 32'h0C00_000B);
      check("rel_pc4", bus.if_pc_plus4, 32'hAC);

      // Redirect overrides stall
      drive(1, 1, 1, 32'h30);
      step("redir");
      check("redir_valid", {31'd0, bus.if_valid}, 32'd0);
      check("redir_addr", bus.imem_addr, 32'h30);
      drive(1, 0, 0, 32'h0);
      step("redir_fetch");
      check("redir_instr", bus.if_instr, 32'h03E0_0008);
      check("redir_pc", bus.if_pc, 32'h30);

      // Misaligned redirect is terminal
      drive(1, 0, 1, 32'h32);
      step("misalign");
      check("mis_err", {31'd0, bus.fetch_err}, 32'd1);
      drive(1, 0, 0, 32'h0);
      for (int i = 0; i < 4; i++) step("err_hold");

      // Last word fetched, next one out of range
      async_reset();
      drive(1, 0, 1, 32'h3FC);
      step("to_3fc");
      drive(1, 0, 0, 32'h0);
      step("fetch_3fc");
      check("last_pc", bus.if_pc, 32'h3FC);
      check("last_pc4", bus.if_pc_plus4, 32'h400);
      step("range");
      check("range_err", {31'd0, bus.fetch_err}, 32'd1);
      check("range_valid", {31'd0, bus.if_valid}, 32'd0);

      // Async reset mid-run at PC=0xB0
      async_reset();
      drive(1, 0, 0, 32'h0);
      for (int i = 0; i < 20 && m_pc != 32'hB0; i++) step("to_b0");
      check("reach_b0", bus.imem_addr, 32'hB0);
      #3;
      async_reset();
      check("rst_addr", bus.imem_addr, 32'hA0);
      step("restart_idle");
      step("restart_fetch");
      check("restart_pc", bus.if_pc, 32'hA0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [31:0] rpc;
         int sel;
         sel = $urandom_range(0, 19);
         if (sel == 0) rpc = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
         else if (sel < 4) rpc = 32'h3F0 + $urandom_range(0, 3) * 4;
         else rpc = $urandom_range(0, 255) * 4;
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 11) == 0, rpc);
         step("rand");
         if (m_dead && $urandom_range(0, 3) == 0) async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
